// File: rtl/rtc_access_scheduler.sv
// rtc_access_scheduler: init write, periodic RTC read bursts and user writes arbitrated onto one bus engine
module rtc_access_scheduler #(
  parameter logic [23:0] REFRESH_CYCLES = 24'd1_000_000,
  parameter logic [7:0]  RD_BASE        = 8'h21,
  parameter int          RD_COUNT       = 6,
  parameter logic [7:0]  INIT_ADDR      = 8'h02,
  parameter logic [7:0]  INIT_DATA      = 8'h10,
  parameter logic [7:0]  TIMEOUT        = 8'd200
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  bus_start,
  output logic                  bus_write,
  output logic [7:0]            bus_addr,
  output logic [7:0]            bus_wdata,
  input  logic                  bus_done,
  input  logic [7:0]            bus_rdata,
  input  logic                  wr_req,
  input  logic [7:0]            wr_addr,
  input  logic [7:0]            wr_data,
  output logic                  wr_ack,
  output logic [8*RD_COUNT-1:0] time_regs,
  output logic                  snap_valid,
  output logic                  busy,
  output logic                  err
);
  typedef enum logic [2:0] {INIT_ISSUE, INIT_WAIT, IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, RD_COMMIT} state_t;
  state_t                state;
  logic [23:0]           rcnt;
  logic                  wrap;
  logic                  refresh_pend;
  logic [7:0]            tcnt;
  logic [2:0]            idx;
  logic [8*RD_COUNT-1:0] shadow;
  assign wrap = rcnt == REFRESH_CYCLES - 24'd1;
  assign busy = state != IDLE;
  // free-running refresh period counter, independent of the FSM
  always_ff @(posedge clk or posedge reset)
    if (reset) rcnt <= '0;
    else rcnt <= wrap ? '0 : rcnt + 24'd1;
  // access sequencer; bus_start is raised on entry to an issue state so it is high for exactly that state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= INIT_ISSUE;
      bus_start    <= 1'b0;
      bus_write    <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      wr_ack       <= 1'b0;
      snap_valid   <= 1'b0;
      err          <= 1'b0;
      time_regs    <= '0;
      shadow       <= '0;
      tcnt         <= '0;
      idx          <= '0;
      refresh_pend <= 1'b0;
    end else begin
      bus_start  <= 1'b0;
      wr_ack     <= 1'b0;
      snap_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        INIT_ISSUE, WR_ISSUE, RD_ISSUE:
          if (!bus_start) begin
            bus_start <= 1'b1;
            bus_write <= 1'b1;
            bus_addr  <= INIT_ADDR;
            bus_wdata <= INIT_DATA;
            tcnt      <= '0;
          end else begin
            state <= state == INIT_ISSUE ? INIT_WAIT : state == WR_ISSUE ? WR_WAIT : RD_WAIT;
            tcnt  <= tcnt + 8'd1;
          end
        INIT_WAIT, WR_WAIT, RD_WAIT:
          if (bus_done) begin
            if (state == RD_WAIT) begin
              shadow[8*idx +: 8] <= bus_rdata;
              if (idx == 3'(RD_COUNT - 1)) state <= RD_COMMIT;
              else begin
                idx       <= idx + 3'd1;
                bus_start <= 1'b1;
                bus_write <= 1'b0;
                bus_addr  <= RD_BASE + 8'(idx) + 8'd1;
                tcnt      <= '0;
                state     <= RD_ISSUE;
              end
            end else begin
              wr_ack <= state == WR_WAIT;
              state  <= IDLE;
            end
          end else if (tcnt == TIMEOUT - 8'd1) begin
            err   <= 1'b1;
            state <= IDLE;
          end else tcnt <= tcnt + 8'd1;
        IDLE:
          if (wr_req && !wr_ack) begin
            bus_start <= 1'b1;
            bus_write <= 1'b1;
            bus_addr  <= wr_addr;
            bus_wdata <= wr_data;
            tcnt      <= '0;
            state     <= WR_ISSUE;
          end else if (refresh_pend) begin
            refresh_pend <= 1'b0;
            idx          <= '0;
            bus_start    <= 1'b1;
            bus_write    <= 1'b0;
            bus_addr     <= RD_BASE;
            tcnt         <= '0;
            state        <= RD_ISSUE;
          end
        RD_COMMIT: begin
          time_regs  <= shadow;
          snap_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (wrap) refresh_pend <= 1'b1;
    end
endmodule

// File: tb/tb_rtc_access_scheduler.sv
// tb_rtc_access_scheduler: scoreboard bench with a behavioural bus engine and RTC register model
module tb_rtc_access_scheduler;
  localparam int RC = 500;
  logic        clk = 1'b0, reset = 1'b1;
  logic        bus_start, bus_write, bus_done, wr_req, wr_ack, snap_valid, busy, err;
  logic [7:0]  bus_addr, bus_wdata, bus_rdata, wr_addr, wr_data;
  logic [47:0] time_regs;
  rtc_access_scheduler #(.REFRESH_CYCLES(24'(RC)), .RD_BASE(8'h21), .RD_COUNT(6),
    .INIT_ADDR(8'h02), .INIT_DATA(8'h10), .TIMEOUT(8'd200)) dut (
    .clk(clk), .reset(reset), .bus_start(bus_start), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_done(bus_done), .bus_rdata(bus_rdata), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .time_regs(time_regs),
    .snap_valid(snap_valid), .busy(busy), .err(err));
  always #5 clk = ~clk;
  int cyc;
  always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;
  int checks = 0, errors = 0;
  int n_start = 0, n_snap = 0, n_ack = 0, n_err = 0, start_cyc = 0, err_cyc = 0, rd0_cyc = 0;
  int fixed_delay = 30, hang_w = 0;
  bit hang_rd = 0;
  logic [16:0] exp_acc[$];
  logic [47:0] exp_snap[$];
  logic [47:0] last_snap;
  logic [7:0]  mem[256], ref_mem[256];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic push_burst();
    logic [47:0] s;
    for (int i = 0; i < 6; i++) begin
      exp_acc.push_back({1'b0, 8'(8'h21 + i), 8'h00});
      s[8*i +: 8] = ref_mem[8'h21 + i];
    end
    exp_snap.push_back(s);
    last_snap = s;
  endtask
  task automatic wait_snap(input int tgt, input int lim);
    for (int i = 0; i < lim && n_snap < tgt; i++) tick();
    chk("snap_seen", n_snap, tgt);
  endtask
  task automatic wait_ack(input int tgt, input int lim);
    for (int i = 0; i < lim && n_ack < tgt; i++) tick();
    chk("ack_seen", n_ack, tgt);
    @(posedge clk);
    #1 wr_req = 1'b0;
  endtask
  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && busy; i++) tick();
    chk("idle_reached", busy, 0);
  endtask
  // monitor: pops the scoreboard whenever the DUT presents an access or a snapshot
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (bus_start) begin
        n_start++;
        start_cyc = cyc;
        if (!bus_write && bus_addr == 8'h21) rd0_cyc = cyc;
        if (exp_acc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: got %0h expected none (cyc %0d)", {bus_write, bus_addr, bus_wdata}, cyc);
        end else chk("access", {bus_write, bus_addr, bus_write ? bus_wdata : 8'h00}, exp_acc.pop_front());
      end
      if (snap_valid) begin
        n_snap++;
        if (exp_snap.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_snap: got %0h expected none", time_regs);
        end else chk("snapshot", time_regs, exp_snap.pop_front());
      end
      if (wr_ack) n_ack++;
      if (err) begin
        n_err++;
        err_cyc = cyc;
      end
    end
  end
  // bus engine model: register file, acks after a delay, can be told to drop accesses
  initial begin
    logic [7:0] a, wd;
    logic       w, hang;
    int         d;
    bus_done = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_done = 1'b0;
      if (!reset && bus_start) begin
        a = bus_addr;
        w = bus_write;
        wd = bus_wdata;
        d = fixed_delay > 0 ? fixed_delay : int'($urandom_range(1, 12));
        hang = 1'b0;
        if (w && hang_w > 0) begin
          hang_w--;
          hang = 1'b1;
        end
        if (!w && hang_rd && a == 8'h22) begin
          hang_rd = 0;
          hang = 1'b1;
        end
        if (!hang) begin
          for (int i = 0; i < d && !reset; i++) @(negedge clk);
          if (!reset) begin
            chk("addr_hold", {bus_addr, w ? bus_wdata : 8'h00}, {a, w ? wd : 8'h00});
            if (w) mem[a] = wd;
            bus_rdata = mem[a];
            bus_done = 1'b1;
          end
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got stuck expected finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] a, d;
    int s0, a0, e0, st0;
    wr_req = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    repeat (3) tick();
    chk("reset_outs", {bus_start, wr_ack, snap_valid, err, bus_write, bus_addr, bus_wdata}, 0);
    chk("reset_time_regs", time_regs, 0);
    chk("reset_busy", busy, 1);
    exp_acc.push_back({1'b1, 8'h02, 8'h10});
    reset = 1'b0;
    wait_idle(200);
    chk("init_start_cyc", start_cyc, 1);
    chk("init_idle_cyc", cyc, 32);
    fixed_delay = 0;
    // first periodic burst
    push_burst();
    wait_snap(1, 700);
    chk("first_burst_cyc", rd0_cyc, RC + 1);
    chk("snap_const", time_regs, 48'h7C7F7E79787B);
    // writes raised during read #3 of a burst
    for (int it = 0; it < 4; it++) begin
      push_burst();
      for (int i = 0; i < 700 && !(bus_start && !bus_write && bus_addr == 8'h23); i++) tick();
      chk("rd3_seen", {bus_start, bus_addr}, {1'b1, 8'h23});
      a = (it % 2 == 0) ? 8'(8'h21 + $urandom_range(0, 5)) : 8'($urandom);
      d = 8'($urandom);
      exp_acc.push_back({1'b1, a, d});
      ref_mem[a] = d;
      s0 = n_snap;
      a0 = n_ack;
      wr_addr = a;
      wr_data = d;
      wr_req = 1'b1;
      wait_snap(s0 + 1, 200);
      tick();
      chk("wr_after_idle", {bus_start, bus_write}, 2'b11);
      wait_ack(a0 + 1, 300);
      repeat (5) tick();
      chk("ack_once", n_ack, a0 + 1);
    end
    // write retried through timeouts while two refresh wraps go by, then exactly one burst
    a = 8'h24;
    d = 8'($urandom);
    for (int i = 0; i < 6; i++) exp_acc.push_back({1'b1, a, d});
    ref_mem[a] = d;
    push_burst();
    hang_w = 5;
    e0 = n_err;
    a0 = n_ack;
    s0 = n_snap;
    st0 = n_start;
    wr_addr = a;
    wr_data = d;
    wr_req = 1'b1;
    wait_ack(a0 + 1, 1500);
    chk("retry_errs", n_err - e0, 5);
    wait_snap(s0 + 1, 300);
    for (int i = 0; i < 600 && cyc % RC != 400; i++) tick();
    chk("one_burst", n_start - st0, 12);
    chk("ack_once_retry", n_ack, a0 + 1);
    // read #2 never completes
    exp_acc.push_back({1'b0, 8'h21, 8'h00});
    exp_acc.push_back({1'b0, 8'h22, 8'h00});
    hang_rd = 1;
    e0 = n_err;
    s0 = n_snap;
    for (int i = 0; i < 800 && n_err == e0; i++) tick();
    chk("rd_timeout_err", n_err, e0 + 1);
    chk("rd_timeout_delay", err_cyc - start_cyc, 200);
    chk("rd_timeout_phase", rd0_cyc % RC, 1);
    chk("rd_timeout_regs", time_regs, last_snap);
    repeat (5) tick();
    chk("rd_timeout_nosnap", n_snap, s0);
    push_burst();
    wait_snap(s0 + 1, 800);
    chk("next_burst_phase", rd0_cyc % RC, 1);
    // reset in the middle of a write
    a = 8'($urandom);
    d = 8'($urandom);
    exp_acc.push_back({1'b1, a, d});
    fixed_delay = 100;
    st0 = n_start;
    a0 = n_ack;
    wr_addr = a;
    wr_data = d;
    wr_req = 1'b1;
    for (int i = 0; i < 800 && n_start == st0; i++) tick();
    repeat (20) tick();
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outs", {bus_start, wr_ack, snap_valid, err, bus_write, bus_addr, bus_wdata}, 0);
    chk("async_reset_regs", time_regs, 0);
    wr_req = 1'b0;
    repeat (3) tick();
    fixed_delay = 30;
    exp_acc.push_back({1'b1, 8'h02, 8'h10});
    reset = 1'b0;
    wait_idle(200);
    chk("reinit_start_cyc", start_cyc, 1);
    chk("no_ack_after_reset", n_ack, a0);
    repeat (5) tick();
    chk("acc_queue_empty", exp_acc.size(), 0);
    chk("snap_queue_empty", exp_snap.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
